// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default pacing limits and the
// transmit-arbiter state encoding.
package uart_pkg;

    localparam int BYTE_W      = 8;
    localparam int DEF_MAX_PKT = 16;
    localparam int DEF_BUSY_TO = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        LOAD      = ST_LOAD,
        ISSUE     = ST_ISSUE,
        WAIT_BUSY = ST_WAIT_BUSY,
        WAIT_DONE = ST_WAIT_DONE
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first active request at or after
// ptr_i (wrapping) wins; returns one-hot winner and its index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic found;

    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte-stream requesters: round-robin
// grant held per packet (capped at MAX_PKT bytes), one tx_en pulse per byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_PKT = DEF_MAX_PKT,
    parameter int BUSY_TO = DEF_BUSY_TO
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        grant,
    output logic [BYTE_W-1:0]       tx_data_in,
    output logic                    tx_en,
    input  logic                    tx_busy,
    output logic                    err_timeout,
    output logic [2:0]              dbg_state_o
);

    localparam int IW   = $clog2(N_REQ);
    localparam int TO_W = $clog2(BUSY_TO + 1);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic              last_q, last_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              tx_en_q, tx_en_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              err_q, err_d;

    logic [N_REQ-1:0]  win_oh;
    logic [IW-1:0]     win_idx;
    logic              win_any;
    logic              accept;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    // Handshake: a byte moves when req_valid[g] and req_ready[g] are both high
    // on a rising edge; ready is only offered to the owner, in LOAD, while the
    // transmitter is idle, so it lasts at most one cycle per byte.
    assign accept = (state_q == LOAD) && (|(grant_q & req_valid)) && !tx_busy;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        byte_cnt_d = byte_cnt_q;
        last_d     = last_q;
        data_d     = data_q;
        tx_en_d    = 1'b0;
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
        req_ready  = '0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (win_any) begin
                    grant_d    = win_oh;
                    owner_d    = win_idx;
                    byte_cnt_d = 8'd0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                req_ready = grant_q & req_valid & {N_REQ{~tx_busy}};
                if (accept) begin
                    data_d     = req_data[int'(owner_q)*BYTE_W +: BYTE_W];
                    last_d     = req_last[owner_q];
                    byte_cnt_d = (byte_cnt_q == 8'(MAX_PKT)) ? byte_cnt_q
                                                             : byte_cnt_q + 8'd1;
                    tx_en_d    = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // Counting starts at 1 so err_timeout lands BUSY_TO cycles after tx_en.
                to_cnt_d = TO_W'(1);
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt_q >= TO_W'(BUSY_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = WAIT_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q || (byte_cnt_q == 8'(MAX_PKT))) begin
                        grant_d  = '0;
                        rr_ptr_d = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + IW'(1);
                        state_d  = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            byte_cnt_q <= 8'd0;
            last_q     <= 1'b0;
            data_q     <= '0;
            tx_en_q    <= 1'b0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            last_q     <= last_d;
            data_q     <= data_d;
            tx_en_q    <= tx_en_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
        end
    end

    assign grant       = grant_q;
    assign tx_data_in  = data_q;
    assign tx_en       = tx_en_q;
    assign err_timeout = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester byte queues, a busy-flag
// transmitter model and a log of every issued {grant, byte}.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N        = 4;
    localparam int MAXP     = 4;
    localparam int BTO      = 16;
    localparam int BUSY_LEN = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]  req_last = '0;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  grant;
    logic [7:0]    tx_data_in;
    logic          tx_en;
    logic          tx_busy = 1'b0;
    logic          err_timeout;
    logic [2:0]    dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  src0[$], src1[$], src2[$], src3[$];
    logic [N-1:0] hs_s = '0;
    logic [11:0] obs_q[$];
    logic [11:0] exp_q[$];
    bit          busy_on = 1'b1;
    int          busy_cnt = 0;

    uart_tx_arbiter #(.N_REQ(N), .MAX_PKT(MAXP), .BUSY_TO(BTO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_data_in  (tx_data_in),
        .tx_en       (tx_en),
        .tx_busy     (tx_busy),
        .err_timeout (err_timeout),
        .dbg_state_o (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // requester drivers and transmitter model, updated just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hs_s[0] && src0.size() > 0) void'(src0.pop_front());
            if (hs_s[1] && src1.size() > 0) void'(src1.pop_front());
            if (hs_s[2] && src2.size() > 0) void'(src2.pop_front());
            if (hs_s[3] && src3.size() > 0) void'(src3.pop_front());
            hs_s = '0;
            if (!rst_n) busy_cnt = 0;
            else if (tx_en && busy_on) busy_cnt = BUSY_LEN;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy = (busy_cnt != 0);
            req_valid[0] = src0.size() > 0;
            req_valid[1] = src1.size() > 0;
            req_valid[2] = src2.size() > 0;
            req_valid[3] = src3.size() > 0;
            {req_last[0], req_data[7:0]}   = (src0.size() > 0) ? src0[0] : 9'h0;
            {req_last[1], req_data[15:8]}  = (src1.size() > 0) ? src1[0] : 9'h0;
            {req_last[2], req_data[23:16]} = (src2.size() > 0) ? src2[0] : 9'h0;
            {req_last[3], req_data[31:24]} = (src3.size() > 0) ? src3[0] : 9'h0;
        end
    end

    // handshake sampling and issue log, mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            hs_s = req_valid & req_ready;
            if (tx_en) obs_q.push_back({grant, tx_data_in});
        end
    end

    task automatic push_src(input int r, input logic last, input logic [7:0] d);
        case (r)
            0: src0.push_back({last, d});
            1: src1.push_back({last, d});
            2: src2.push_back({last, d});
            default: src3.push_back({last, d});
        endcase
    endtask

    task automatic clear_srcs();
        src0.delete(); src1.delete(); src2.delete(); src3.delete();
        hs_s = '0;
    endtask

    task automatic wait_grant(input logic [3:0] g, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (grant === g) ok = 1'b1;
        end
    endtask

    task automatic wait_tx_en(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (tx_en === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (src0.size() == 0 && src1.size() == 0 && src2.size() == 0 && src3.size() == 0)
                ok = 1'b1;
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_srcs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (tx_en !== 1'b0) begin failures++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
        checks++; if (tx_data_in !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", tx_data_in); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rst_n = 1'b1;
        @(negedge clk);
        obs_q.delete();
    endtask

    task automatic test_single_byte();
        @(negedge clk);
        push_src(2, 1'b1, 8'h55);
        @(negedge clk);  // cycle 0
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_c0_grant: got %b want 0000", grant); end
        @(negedge clk);  // cycle 1
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_c1_grant: got %b want 0100", grant); end
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_c1_ready: got %b want 0100", req_ready); end
        checks++; if (tx_en !== 1'b0) begin failures++; $display("FAIL single_c1_tx_en: got %b want 0", tx_en); end
        @(negedge clk);  // cycle 2
        checks++; if (tx_en !== 1'b1) begin failures++; $display("FAIL single_c2_tx_en: got %b want 1", tx_en); end
        checks++; if (tx_data_in !== 8'h55) begin failures++; $display("FAIL single_c2_data: got %h want 55", tx_data_in); end
        @(negedge clk);  // cycle 3
        checks++; if (tx_en !== 1'b0) begin failures++; $display("FAIL single_c3_tx_en: got %b want 0", tx_en); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_c3_ready: got %b want 0000", req_ready); end
        repeat (9) @(negedge clk);  // cycle 12: busy just fell
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_c12_grant: got %b want 0100", grant); end
        @(negedge clk);  // cycle 13
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL single_c13_grant: got %b want 0000", grant); end
        checks++; if (obs_q.size() != 1 || obs_q[0] !== 12'h455) begin
            failures++; $display("FAIL single_log: got size %0d first %h want size 1 first 455",
                                 obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 12'h0);
        end
        obs_q.delete();
    endtask

    task automatic test_round_robin();
        bit ok;
        @(negedge clk);
        push_src(0, 1'b1, 8'h22); push_src(0, 1'b1, 8'h22);
        push_src(1, 1'b1, 8'h00); push_src(1, 1'b1, 8'h00);
        exp_q = '{12'h122, 12'h200, 12'h122, 12'h200};
        wait_drain(400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rr_drain: got timeout want drained"); end
        checks++; if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rr_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (obs_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL rr_order[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                end
        end
        obs_q.delete();
    endtask

    task automatic test_packet_hold();
        bit ok;
        @(negedge clk);
        push_src(1, 1'b0, 8'h22); push_src(1, 1'b0, 8'h00); push_src(1, 1'b1, 8'h22);
        wait_grant(4'b0010, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL hold_grant1: got %b want 0010", grant); end
        push_src(3, 1'b1, 8'h33);
        exp_q = '{12'h222, 12'h200, 12'h222, 12'h833};
        wait_drain(400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL hold_drain: got timeout want drained"); end
        checks++; if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL hold_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (obs_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL hold_order[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                end
        end
        obs_q.delete();
    endtask

    task automatic test_forced_release();
        bit ok;
        @(negedge clk);
        for (int i = 1; i <= 6; i++) push_src(0, 1'b0, 8'(i));
        wait_grant(4'b0001, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL force_grant0: got %b want 0001", grant); end
        push_src(2, 1'b1, 8'h77);
        exp_q = '{12'h101, 12'h102, 12'h103, 12'h104, 12'h477, 12'h105, 12'h106};
        wait_drain(600, ok);
        checks++; if (!ok) begin failures++; $display("FAIL force_drain: got timeout want drained"); end
        checks++; if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL force_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (obs_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL force_order[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                end
        end
        // packet still open: requester 0 keeps the grant, waiting in LOAD
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL force_open_grant: got %b want 0001", grant); end
        checks++; if (dbg_state !== ST_LOAD) begin failures++; $display("FAIL force_open_state: got %0d want 1", dbg_state); end
        do_reset();
    endtask

    task automatic test_busy_timeout();
        bit ok;
        busy_on = 1'b0;
        @(negedge clk);
        push_src(0, 1'b0, 8'hAA); push_src(0, 1'b1, 8'hBB);
        wait_tx_en(20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL to_first_tx_en: got none want pulse"); end
        repeat (BTO - 1) @(negedge clk);
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_early: got %b want 0", err_timeout); end
        @(negedge clk);
        checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_set: got %b want 1", err_timeout); end
        exp_q = '{12'h1AA, 12'h1BB};
        wait_drain(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL to_drain: got timeout want drained"); end
        checks++; if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL to_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (obs_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL to_order[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                end
        end
        checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky: got %b want 1", err_timeout); end
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL to_idle_grant: got %b want 0000", grant); end
        obs_q.delete();
        busy_on = 1'b1;
    endtask

    task automatic test_reset_mid_byte();
        bit ok;
        @(negedge clk);
        push_src(1, 1'b1, 8'h5A);
        wait_tx_en(20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_tx_en: got none want pulse"); end
        repeat (3) @(negedge clk);
        checks++; if (dbg_state !== ST_WAIT_DONE) begin failures++; $display("FAIL rst_pre_state: got %0d want 4", dbg_state); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rst_grant: got %b want 0000", grant); end
        checks++; if (tx_en !== 1'b0) begin failures++; $display("FAIL rst_tx_en_low: got %b want 0", tx_en); end
        checks++; if (tx_data_in !== 8'h00) begin failures++; $display("FAIL rst_data: got %h want 00", tx_data_in); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", err_timeout); end
        clear_srcs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        @(negedge clk);
        push_src(0, 1'b1, 8'h11);
        push_src(1, 1'b1, 8'h22);
        exp_q = '{12'h111, 12'h222};
        wait_drain(300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_drain: got timeout want drained"); end
        checks++; if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rst_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (obs_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL rst_order[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                end
        end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_hold();
        test_forced_release();
        test_busy_timeout();
        test_reset_mid_byte();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter between several byte-stream requesters. Sits between up to N_REQ producer blocks (status reporters, debug dumpers, LED/heartbeat messages) and the UART transmitter's `tx_data_in`/`tx_en` inputs. It issues each byte as a single-cycle `tx_en` pulse and paces on the transmitter's busy flag. A grant is held for a whole packet, up to a maximum length.

## Interface
- N_REQ, 4, number of requesters (2..8)
- MAX_PKT, 16, bytes per grant before forced re-arbitration (1..255)
- BUSY_TO, 16, cycles to wait for `tx_busy` to rise after a `tx_en` pulse

- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester byte valid
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  N_REQ  byte is the last of the packet
- req_ready  out  N_REQ  byte accepted this cycle (combinational)
- grant  out  N_REQ  one-hot current owner, 0 when idle (registered)
- tx_data_in  out  8  byte to transmitter (registered, held stable)
- tx_en  out  1  one-cycle transmit strobe (registered)
- tx_busy  in  1  transmitter shifting a frame
- err_timeout  out  1  sticky flag; `tx_busy` never rose within BUSY_TO

## Operation
- States: IDLE, LOAD, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - If any `req_valid` is high, choose the winner by round-robin. Search starts at `rr_ptr` and wraps.
  - Register the winner into `grant`, clear `byte_cnt`, go to LOAD.
  - Otherwise `grant`=0.
- **LOAD**
  - `req_ready[g]` = `req_valid[g]` & `!tx_busy`.
  - On acceptance: capture `req_data[g]` into `tx_data_in`, capture `req_last[g]` into `last_q`, increment `byte_cnt`, go to ISSUE.
  - If `req_valid[g]` is low, stay in LOAD and keep the grant. Gaps inside a packet are allowed.
- **ISSUE**: `tx_en`=1 for exactly this cycle, then go to WAIT_BUSY.
- **WAIT_BUSY**
  - When `tx_busy` is seen high, go to WAIT_DONE.
  - If BUSY_TO cycles elapse first, set `err_timeout` and go to WAIT_DONE.
- **WAIT_DONE**: when `tx_busy` is low:
  - If `last_q` is set or `byte_cnt`==MAX_PKT: go to IDLE, set `rr_ptr` to owner+1 (mod N_REQ), clear `grant`.
  - Else go to LOAD.
- Requester rules:
  - Once `req_valid` is asserted, hold it and its data until `req_ready`.
  - `req_ready` is never high for a non-granted requester.
  - `req_ready` is high for at most one cycle per byte.
- `byte_cnt` is 8 bits and saturates at MAX_PKT. The forced release does not require `req_last`; the requester simply re-competes for the remainder of its packet.
- `err_timeout` clears only on reset.

## Timing
- Reset values:
  - `grant`=0, `tx_en`=0, `tx_data_in`=8'h00, `err_timeout`=0, `req_ready`=0.
  - State IDLE, `rr_ptr`=0, so requester 0 has first priority.
- Latency from IDLE to first byte, with `req_valid` rising in cycle 0:
  - cycle 1: `grant` set, `req_ready` high.
  - cycle 2: `tx_en` pulse, with `tx_data_in` already valid in that cycle.
- Back-to-back bytes within a packet: the next `req_ready` appears in the first cycle after `tx_busy` falls.
- Simultaneous requests in IDLE: exactly one wins. Requesters that lose keep `req_valid` high and see no `req_ready`.
- `tx_busy` already high in LOAD: acceptance is withheld until it falls.
- `tx_busy` rising in the same cycle as ISSUE is legal; WAIT_BUSY exits on the next cycle.
- Asynchronous reset mid-operation: outputs drop immediately to their reset values. The in-flight byte is abandoned and the requester must resend it.

## Structure
- Shared package `uart_pkg`:
  - state encoding localparams (IDLE..WAIT_DONE, 3 bits);
  - UART byte width constant 8;
  - default MAX_PKT and BUSY_TO.
- Sub-module `rr_arbiter`:
  - combinational N_REQ round-robin picker;
  - inputs: request vector and `rr_ptr`;
  - outputs: one-hot winner and its index.
  - Reusable by the future RX dispatcher.
- The FSM, counters and the data register live in `uart_tx_arbiter`.

## Test plan
- **Single byte**: requester 2 sends 8'h55 with `last`=1; transmitter model holds busy for 10 cycles after `tx_en`.
  - Expect `grant`=4'b0100 in cycle 1, `tx_en` one cycle with `tx_data_in`=8'h55 in cycle 2, `grant`=0 after busy falls.
- **Round-robin**: requesters 0 and 1 each hold 1-byte packets 8'h22 / 8'h00 continuously.
  - Expect the issue order 0,1,0,1.
  - Requester 0 is never granted twice in a row.
- **Packet hold**: requester 1 sends 3 bytes (8'h22, 8'h00, 8'h22 with `last`); requester 3 requests meanwhile.
  - Expect all 3 bytes issued before `grant`=4'b1000.
- **Forced release**: MAX_PKT=4; requester 0 streams 6 bytes with no `last`; requester 2 is pending.
  - Expect 4 bytes from 0, then requester 2's packet, then the remaining 2 bytes from 0.
- **Busy timeout**: transmitter model never raises busy.
  - Expect `err_timeout`=1 exactly BUSY_TO cycles after `tx_en`.
  - The FSM still proceeds and the next byte is issued.
- **Reset mid-byte**: assert `rst_n`=0 during WAIT_DONE.
  - Expect `grant`, `tx_en` and `tx_data_in` at 0 immediately.
  - After release, requester 0 wins first.
